// File: rtl/wb_commit_arb_pkg.sv
// rtl/wb_commit_arb_pkg.sv - shared types and constants for the writeback/commit arbiter
package wb_commit_arb_pkg;

  localparam int NUM_THREADS_D = 4;
  localparam int XLEN_D        = 32;
  localparam int NR_BITS_D     = 6;
  localparam int WIS_W_D       = 2;
  localparam int PC_BITS_D     = 30;
  localparam int UUID_W_D      = 44;
  localparam int DATA_W_D      = NUM_THREADS_D * XLEN_D;
  localparam int RETIRE_CNT_W  = $clog2(NUM_THREADS_D + 1);

  typedef struct packed {
    logic [UUID_W_D-1:0]      uuid;
    logic [WIS_W_D-1:0]       wis;
    logic [NUM_THREADS_D-1:0] tmask;
    logic [PC_BITS_D-1:0]     pc;
    logic                     wb;
    logic [NR_BITS_D-1:0]     rd;
    logic [DATA_W_D-1:0]      data;
    logic                     sop;
    logic                     eop;
  } commit_beat_t;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_e;

  function automatic logic [RETIRE_CNT_W-1:0] count_active(input logic [NUM_THREADS_D-1:0] tmask);
    count_active = '0;
    for (int t = 0; t < NUM_THREADS_D; t++) begin
      count_active = count_active + RETIRE_CNT_W'(tmask[t]);
    end
  endfunction

endpackage

// File: rtl/wb_commit_arb_if.sv
// rtl/wb_commit_arb_if.sv - commit-beat inputs and writeback/retire outputs of one issue slot
interface wb_commit_arb_if
  import wb_commit_arb_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int NUM_THREADS = NUM_THREADS_D,
  parameter int XLEN        = XLEN_D,
  parameter int NR_BITS     = NR_BITS_D,
  parameter int WIS_W       = WIS_W_D,
  parameter int PC_BITS     = PC_BITS_D,
  parameter int UUID_W      = UUID_W_D
);

  logic [NUM_UNITS-1:0]                        commit_valid;
  logic [NUM_UNITS-1:0]                        commit_ready;
  logic [NUM_UNITS-1:0][UUID_W-1:0]            commit_uuid;
  logic [NUM_UNITS-1:0][WIS_W-1:0]             commit_wis;
  logic [NUM_UNITS-1:0][NUM_THREADS-1:0]       commit_tmask;
  logic [NUM_UNITS-1:0][PC_BITS-1:0]           commit_pc;
  logic [NUM_UNITS-1:0]                        commit_wb;
  logic [NUM_UNITS-1:0][NR_BITS-1:0]           commit_rd;
  logic [NUM_UNITS-1:0][NUM_THREADS*XLEN-1:0]  commit_data;
  logic [NUM_UNITS-1:0]                        commit_sop;
  logic [NUM_UNITS-1:0]                        commit_eop;

  logic                                        wb_valid;
  logic [UUID_W-1:0]                           wb_uuid;
  logic [WIS_W-1:0]                            wb_wis;
  logic [NUM_THREADS-1:0]                      wb_tmask;
  logic [PC_BITS-1:0]                          wb_pc;
  logic [NR_BITS-1:0]                          wb_rd;
  logic [NUM_THREADS*XLEN-1:0]                 wb_data;
  logic                                        wb_sop;
  logic                                        wb_eop;

  logic                                        retire_valid;
  logic [$clog2(NUM_THREADS+1)-1:0]            retire_count;

  // master: execution units and writeback sink; slave: the arbiter
  modport master (
    output commit_valid, commit_uuid, commit_wis, commit_tmask, commit_pc,
           commit_wb, commit_rd, commit_data, commit_sop, commit_eop,
    input  commit_ready,
    input  wb_valid, wb_uuid, wb_wis, wb_tmask, wb_pc, wb_rd, wb_data, wb_sop, wb_eop,
    input  retire_valid, retire_count
  );

  modport slave (
    input  commit_valid, commit_uuid, commit_wis, commit_tmask, commit_pc,
           commit_wb, commit_rd, commit_data, commit_sop, commit_eop,
    output commit_ready,
    output wb_valid, wb_uuid, wb_wis, wb_tmask, wb_pc, wb_rd, wb_data, wb_sop, wb_eop,
    output retire_valid, retire_count
  );

endinterface

// File: rtl/wb_commit_arb_rr_lock_arbiter.sv
// rtl/wb_commit_arb_rr_lock_arbiter.sv - round-robin grant that holds one unit for a multi-beat packet
module rr_lock_arbiter
  import wb_commit_arb_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_UNITS-1:0] valid,
  input  logic                 lock,
  input  logic                 unlock,
  output logic [NUM_UNITS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_OPEN;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    int  idx;
    logic found;
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant     = '0;
    grant_idx = ptr_q;
    idx       = 0;
    found     = 1'b0;

    case (state_q)
      ARB_LOCKED: begin
        grant_idx        = owner_q;
        grant[owner_q]   = valid[owner_q];
      end
      default: begin
        for (int k = 0; k < NUM_UNITS; k++) begin
          idx = (int'(ptr_q) + k) % NUM_UNITS;
          if (!found && valid[idx]) begin
            found     = 1'b1;
            grant_idx = IDX_W'(idx);
          end
        end
        grant[grant_idx] = found;
      end
    endcase

    // pointer moves only when a packet completes, so a locked unit never loses its turn
    if (unlock) begin
      state_d = ARB_OPEN;
      ptr_d   = IDX_W'((int'(grant_idx) + 1) % NUM_UNITS);
    end else if (lock) begin
      state_d = ARB_LOCKED;
      owner_d = grant_idx;
    end
  end

endmodule

// File: rtl/wb_commit_arb.sv
// rtl/wb_commit_arb.sv - per-slot writeback/commit arbiter; WB_COMMIT_PERF_EN adds perf counters
module wb_commit_arb
  import wb_commit_arb_pkg::*;
#(
  parameter int NUM_UNITS = 4
`ifdef WB_COMMIT_PERF_EN
  , parameter int PERF_CTR_BITS = 44
`endif
) (
  input  logic                                        clk,
  input  logic                                        reset,
  wb_commit_arb_if.slave                              bus
`ifdef WB_COMMIT_PERF_EN
  , output logic [PERF_CTR_BITS-1:0]                  perf_stalls,
  output logic [NUM_UNITS-1:0][PERF_CTR_BITS-1:0]     perf_commits
`endif
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 fire;
  logic                 lock;
  logic                 unlock;
  commit_beat_t         beat;

  rr_lock_arbiter #(
    .NUM_UNITS (NUM_UNITS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .valid     (bus.commit_valid),
    .lock      (lock),
    .unlock    (unlock),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    beat       = '0;
    beat.uuid  = bus.commit_uuid[grant_idx];
    beat.wis   = bus.commit_wis[grant_idx];
    beat.tmask = bus.commit_tmask[grant_idx];
    beat.pc    = bus.commit_pc[grant_idx];
    beat.wb    = bus.commit_wb[grant_idx];
    beat.rd    = bus.commit_rd[grant_idx];
    beat.data  = bus.commit_data[grant_idx];
    beat.sop   = bus.commit_sop[grant_idx];
    beat.eop   = bus.commit_eop[grant_idx];
  end

  assign bus.commit_ready = grant;
  assign fire             = |(grant & bus.commit_valid);
  assign lock             = fire && !beat.eop;
  assign unlock           = fire && beat.eop;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.wb_valid     <= 1'b0;
      bus.wb_uuid      <= '0;
      bus.wb_wis       <= '0;
      bus.wb_tmask     <= '0;
      bus.wb_pc        <= '0;
      bus.wb_rd        <= '0;
      bus.wb_data      <= '0;
      bus.wb_sop       <= 1'b0;
      bus.wb_eop       <= 1'b0;
      bus.retire_valid <= 1'b0;
      bus.retire_count <= '0;
    end else begin
      bus.wb_valid <= fire && beat.wb;
      if (fire && beat.wb) begin
        bus.wb_uuid  <= beat.uuid;
        bus.wb_wis   <= beat.wis;
        bus.wb_tmask <= beat.tmask;
        bus.wb_pc    <= beat.pc;
        bus.wb_rd    <= beat.rd;
        bus.wb_data  <= beat.data;
        bus.wb_sop   <= beat.sop;
        bus.wb_eop   <= beat.eop;
      end
      // no-writeback beats still retire, so the scoreboard sees every eop
      bus.retire_valid <= unlock;
      bus.retire_count <= unlock ? count_active(beat.tmask) : '0;
    end
  end

`ifdef WB_COMMIT_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls  <= '0;
      perf_commits <= '0;
    end else begin
      perf_stalls <= perf_stalls + PERF_CTR_BITS'($countones(bus.commit_valid & ~grant));
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (grant[i] && bus.commit_valid[i]) begin
          perf_commits[i] <= perf_commits[i] + PERF_CTR_BITS'(1);
        end
      end
    end
  end
`endif

endmodule
